// File: rtl/odd_chk_pkg.sv
// -----------------------------------------------------------------------------
// odd_chk_pkg
// Shared definitions for the odd up/down counter checker:
//   - Q_W        : width of the observed counter value
//   - ERR_CNT_W  : width of the saturating error counter
//   - STEP       : counter increment/decrement per sample
//   - state_t    : checker state encoding (IDLE / HUNT / LOCKED)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package odd_chk_pkg;

    localparam int Q_W       = 4;
    localparam int ERR_CNT_W = 8;

    localparam logic [Q_W-1:0] STEP = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/odd_chk_expect.sv
// -----------------------------------------------------------------------------
// odd_chk_expect
// Purely combinational predictor: from the previous sample and the direction
// sampled with it, computes the value the counter must show next and whether
// that step crosses the modulo-16 boundary.
//
// Ports:
//   q_prev_i  in   Q_W  previous sampled counter value (reference)
//   y_prev_i  in   1    direction sampled together with q_prev_i (0 = up)
//   q_exp_o   out  Q_W  expected next counter value (modulo 2**Q_W)
//   wrap_o    out  1    expected step wraps (15->1 up, 1->15 down)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module odd_chk_expect
    import odd_chk_pkg::*;
(
    input  logic [Q_W-1:0] q_prev_i,
    input  logic           y_prev_i,
    output logic [Q_W-1:0] q_exp_o,
    output logic           wrap_o
);

    always_comb begin
        q_exp_o = y_prev_i ? (q_prev_i - STEP) : (q_prev_i + STEP);
        // A modular step crosses the boundary exactly when the result moves
        // the "wrong" way numerically: smaller after an up step, larger after
        // a down step. For odd values that is only 15->1 and 1->15.
        wrap_o  = y_prev_i ? (q_exp_o > q_prev_i) : (q_exp_o < q_prev_i);
    end

endmodule

// File: rtl/odd_count_checker.sv
// -----------------------------------------------------------------------------
// odd_count_checker
// Watches an odd-valued 4-bit up/down counter (step 2) and locks onto it after
// LOCK_LEN consecutive correct steps. While locked, a wrong or even sample
// raises err and drops back to hunting; legal boundary crossings raise wrap.
//
// Parameters:
//   LOCK_LEN  consecutive correct steps (1..15) required to reach LOCKED
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst       in   1  asynchronous active-low reset
//   Q         in   4  observed counter value
//   Y         in   1  observed direction (0 = up +2, 1 = down -2)
//   locked    out  1  high while LOCKED
//   err       out  1  one-cycle pulse on a mismatch while LOCKED
//   odd_viol  out  1  one-cycle pulse on an even sample (not in IDLE)
//   wrap      out  1  one-cycle pulse on a legal wrap while LOCKED
//   dir       out  1  Y registered at the last edge
//   err_cnt   out  8  saturating count of err pulses
//
// Build option:
//   ODD_CHK_ERRCNT_EN  defined   -> err_cnt is a real saturating counter
//                      undefined -> err_cnt is tied to zero, no counter flops
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module odd_count_checker
    import odd_chk_pkg::*;
#(
    parameter int unsigned LOCK_LEN = 3
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [Q_W-1:0]       Q,
    input  logic                 Y,
    output logic                 locked,
    output logic                 err,
    output logic                 odd_viol,
    output logic                 wrap,
    output logic                 dir,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_LEN);

    state_t         state_q;
    logic [3:0]     run_q;
    logic [Q_W-1:0] q_ref_q;
    logic           y_ref_q;
    logic           locked_q;
    logic           err_q;
    logic           odd_viol_q;
    logic           wrap_q;
    logic           dir_q;

    logic [Q_W-1:0] q_exp;
    logic           step_wrap;
    logic           sample_odd;
    logic           match;
    logic [3:0]     run_d;
    logic           err_event;

    odd_chk_expect u_expect (
        .q_prev_i (q_ref_q),
        .y_prev_i (y_ref_q),
        .q_exp_o  (q_exp),
        .wrap_o   (step_wrap)
    );

    // An even sample is always a mismatch, even if the reference itself was
    // even and would otherwise predict it.
    always_comb begin
        sample_odd = Q[0];
        match      = sample_odd && (Q == q_exp);
        run_d      = run_q + 4'd1;
        err_event  = (state_q == ST_LOCKED) && !match;
    end

    // Reference sample: every sample becomes the basis for the next
    // expectation. It needs no reset because IDLE always reloads it before
    // it is ever compared.
    always_ff @(posedge clk) begin
        q_ref_q <= Q;
        y_ref_q <= Y;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            run_q      <= 4'd0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            odd_viol_q <= 1'b0;
            wrap_q     <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            dir_q      <= Y;
            err_q      <= 1'b0;
            odd_viol_q <= 1'b0;
            wrap_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q  <= ST_HUNT;
                    run_q    <= 4'd0;
                    locked_q <= 1'b0;
                end
                ST_HUNT: begin
                    odd_viol_q <= !sample_odd;
                    if (match) begin
                        run_q <= run_d;
                        if (run_d == LOCK_RUN) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end
                    end else begin
                        run_q <= 4'd0;
                    end
                end
                ST_LOCKED: begin
                    odd_viol_q <= !sample_odd;
                    if (match) begin
                        wrap_q <= step_wrap;
                    end else begin
                        err_q    <= 1'b1;
                        state_q  <= ST_HUNT;
                        run_q    <= 4'd0;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    run_q    <= 4'd0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ODD_CHK_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : (v + 1'b1);
    endfunction

    always_comb begin
        err_cnt_d = err_event ? sat_inc(err_cnt_q) : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_event;
    assign unused_err_event = err_event;
    assign err_cnt          = '0;
`endif

    assign locked   = locked_q;
    assign err      = err_q;
    assign odd_viol = odd_viol_q;
    assign wrap     = wrap_q;
    assign dir      = dir_q;

endmodule

// File: tb/tb_odd_count_checker.sv
// -----------------------------------------------------------------------------
// tb_odd_count_checker
// Self-checking bench for odd_count_checker (LOCK_LEN = 3). Expected output
// records are queued when a sample is driven and compared after the edge that
// samples it. Works with or without ODD_CHK_ERRCNT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_odd_count_checker;

    localparam int LOCK_LEN = 3;

    // Flag bits of an expectation record: {locked, err, odd_viol, wrap, dir}
    localparam logic [4:0] F_L = 5'b10000;
    localparam logic [4:0] F_E = 5'b01000;
    localparam logic [4:0] F_O = 5'b00100;
    localparam logic [4:0] F_W = 5'b00010;
    localparam logic [4:0] F_D = 5'b00001;

    typedef struct {
        logic [3:0] q;
        logic       y;
        logic [4:0] flags;
    } vec_t;

    typedef struct {
        logic [4:0] flags;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] Q   = 4'd0;
    logic       Y   = 1'b0;
    logic       locked, err, odd_viol, wrap, dir;
    logic [7:0] err_cnt;

    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;
    exp_t sb[$];
    vec_t tbl[$];

    odd_count_checker #(.LOCK_LEN(LOCK_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .Q        (Q),
        .Y        (Y),
        .locked   (locked),
        .err      (err),
        .odd_viol (odd_viol),
        .wrap     (wrap),
        .dir      (dir),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual{L,E,O,W,D,cnt}=%b_%h required=%b_%h",
                     name, act[12:8], act[7:0], req[12:8], req[7:0]);
        end
    endtask

    task automatic add(input logic [3:0] q, input logic y, input logic [4:0] fl);
        vec_t v;
        v.q = q; v.y = y; v.flags = fl;
        tbl.push_back(v);
    endtask

    // Drive one sample, queue its expectation, compare after the sampling edge.
    task automatic step(input string name, input logic [3:0] q, input logic y, input logic [4:0] fl);
        exp_t e;
        exp_t got;
        @(negedge clk);
        Q = q;
        Y = y;
`ifdef ODD_CHK_ERRCNT_EN
        if ((fl & F_E) != 5'b0 && exp_cnt < 255) exp_cnt++;
`endif
        e.flags = fl;
        e.cnt   = 8'(exp_cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty actual=0 required=1", name);
        end else begin
            got = sb.pop_front();
            check(name, {locked, err, odd_viol, wrap, dir, err_cnt}, {got.flags, got.cnt});
        end
    endtask

    initial begin
        // Lock-up, wrap, direction change, even sample while locked,
        // broken hunt, relock.
        add(4'd1,  1'b0, 5'b0);
        add(4'd3,  1'b0, 5'b0);
        add(4'd5,  1'b0, 5'b0);
        add(4'd7,  1'b0, F_L);
        add(4'd9,  1'b0, F_L);
        add(4'd11, 1'b0, F_L);
        add(4'd13, 1'b0, F_L);
        add(4'd15, 1'b0, F_L);
        add(4'd1,  1'b0, F_L | F_W);
        add(4'd3,  1'b0, F_L);
        add(4'd5,  1'b0, F_L);
        add(4'd7,  1'b0, F_L);
        add(4'd9,  1'b0, F_L);
        add(4'd11, 1'b1, F_L | F_D);
        add(4'd9,  1'b1, F_L | F_D);
        add(4'd7,  1'b1, F_L | F_D);
        add(4'd5,  1'b1, F_L | F_D);
        add(4'd3,  1'b1, F_L | F_D);
        add(4'd1,  1'b1, F_L | F_D);
        add(4'd15, 1'b1, F_L | F_W | F_D);
        add(4'd13, 1'b1, F_L | F_D);
        add(4'd11, 1'b1, F_L | F_D);
        add(4'd9,  1'b1, F_L | F_D);
        add(4'd7,  1'b1, F_L | F_D);
        add(4'd5,  1'b1, F_L | F_D);
        add(4'd6,  1'b1, F_E | F_O | F_D);
        add(4'd4,  1'b1, F_O | F_D);
        add(4'd5,  1'b0, 5'b0);
        add(4'd7,  1'b0, 5'b0);
        add(4'd9,  1'b0, 5'b0);
        add(4'd13, 1'b0, 5'b0);
        add(4'd15, 1'b0, 5'b0);
        add(4'd1,  1'b0, 5'b0);
        add(4'd3,  1'b0, F_L);
        add(4'd5,  1'b0, F_L);

        // Reset state, including while the clock runs.
        #2;
        check("reset_t2", {locked, err, odd_viol, wrap, dir, err_cnt}, 13'b0);
        #10;
        check("reset_t12", {locked, err, odd_viol, wrap, dir, err_cnt}, 13'b0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl%0d_q%0d", i, tbl[i].q), tbl[i].q, tbl[i].y, tbl[i].flags);
        end

        // Short asynchronous reset between edges while locked.
        rst = 1'b0;
        #2;
        check("async_reset", {locked, err, odd_viol, wrap, dir, err_cnt}, 13'b0);
        #1;
        rst = 1'b1;
        exp_cnt = 0;
        step("relock_idle", 4'd13, 1'b0, 5'b0);
        step("relock_r1",   4'd15, 1'b0, 5'b0);
        step("relock_r2",   4'd1,  1'b0, 5'b0);
        step("relock_lock", 4'd3,  1'b0, F_L);
        step("relock_hold", 4'd5,  1'b0, F_L);

        // Repeated mismatch + relock to push err_cnt into saturation.
        for (int k = 0; k < 300; k++) begin
            step($sformatf("sat%0d_err", k), 4'd9,  1'b0, F_E);
            step($sformatf("sat%0d_r1", k),  4'd11, 1'b0, 5'b0);
            step($sformatf("sat%0d_r2", k),  4'd13, 1'b0, 5'b0);
            step($sformatf("sat%0d_lk", k),  4'd15, 1'b0, F_L);
        end
`ifdef ODD_CHK_ERRCNT_EN
        check("err_cnt_final", {5'b0, err_cnt}, {5'b0, 8'd255});
`else
        check("err_cnt_final", {5'b0, err_cnt}, {5'b0, 8'd0});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
